locked_seq_core: RTL
====================

LOCKED_SEQ_CORE -- requirements
Module: locked_seq_core

Interface
REQ-001 SHALL have parameter IN_W, default 32, meaning the input word width (2 or more).
REQ-002 SHALL have parameter OUT_W, default 32, meaning the output word width, an integer multiple of KEY_W.
REQ-003 SHALL have parameter KEY_W, default 16, meaning the key length in bits (4..32).
REQ-004 SHALL have parameter KEY_VAL, default 16'hA5C3, meaning the correct key, KEY_W bits wide.
REQ-005 SHALL have parameter STAGES, default 2, meaning the number of pipeline register stages (1..4).
REQ-006 SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive failed key checks before blocking (1..7).
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, the reset: synchronous and active-high.
REQ-009 SHALL have port in_data, input, IN_W bits, the operand word.
REQ-010 SHALL have port in_valid, input, 1 bit, qualifying in_data this cycle.
REQ-011 SHALL have port key_bit, input, 1 bit, the serial key data.
REQ-012 SHALL have port key_shift, input, 1 bit, which shifts key_bit in this cycle.
REQ-013 SHALL have port key_done, input, 1 bit, which requests a key check.
REQ-014 SHALL have port out_data, output, OUT_W bits, the result word.
REQ-015 SHALL have port out_valid, output, 1 bit, qualifying out_data.
REQ-016 SHALL have port unlocked, output, 1 bit, high while the FSM is in UNLOCKED.
REQ-017 SHALL have port key_err, output, 1 bit, a one-cycle pulse on each failed or malformed check.

Function
REQ-018 SHALL compute the core function y[j] = x[j%IN_W] ^ (x[(j+1)%IN_W] & ~x[(j+2)%IN_W]) for j = 0..OUT_W-1.
REQ-019 SHALL form mask = (key_reg ^ KEY_VAL) replicated OUT_W/KEY_W times in LOCKED/LOADING, all-zero in UNLOCKED.
REQ-020 SHALL sample the mask in the same cycle as in_data at stage 1, and SHALL NOT apply a mid-pipeline mask change to words already in flight.
REQ-021 SHALL drive out_data = y ^ mask and out_valid exactly STAGES cycles after in_valid, with no stalls and a throughput of one word per cycle.
REQ-022 SHALL implement FSM states LOCKED, LOADING, UNLOCKED and BLOCKED.
REQ-023 SHALL, on key_shift in LOCKED or LOADING, set key_reg <= {key_reg[KEY_W-2:0], key_bit} (MSB first), increment bit_cnt (saturating at KEY_W), and enter LOADING.
REQ-024 SHALL, on key_done with bit_cnt == KEY_W and key_reg == KEY_VAL, go to UNLOCKED and clear fail_cnt.
REQ-025 SHALL, on key_done with a mismatch or bit_cnt != KEY_W, pulse key_err, increment fail_cnt, clear bit_cnt, and return to LOCKED; key_reg SHALL be retained.
REQ-026 SHALL give key_done priority when it coincides with key_shift; that key_shift SHALL be ignored.
REQ-027 SHALL ignore key_shift and key_done in UNLOCKED and BLOCKED; key_reg SHALL stay frozen there.
REQ-028 SHALL force out_data to all-zero in BLOCKED while still producing out_valid on schedule.

Reset
REQ-029 SHALL, on rst, set FSM=LOCKED, key_reg=0, bit_cnt=0, fail_cnt=0, all pipeline valid bits=0, out_valid=0, out_data=0, unlocked=0, key_err=0.
REQ-030 SHALL let rst override all other inputs in the same cycle, including mid-load and with words in flight; in-flight words SHALL be discarded.

Configuration
REQ-031 SHALL, when macro LOCK_BLOCK_EN is defined, enter BLOCKED from the failure that makes fail_cnt reach MAX_FAIL; only rst exits BLOCKED.
REQ-032 SHALL, without LOCK_BLOCK_EN, never enter BLOCKED: fail_cnt saturates at MAX_FAIL and key loading remains possible indefinitely.

Verification (IN_W=OUT_W=32, KEY_W=16, KEY_VAL=16'hA5C3, STAGES=2, MAX_FAIL=3)
REQ-033 SHALL cover: reset, then in_data=0 with in_valid -> out_valid and out_data=32'hA5C3A5C3 two cycles later, unlocked=0.
REQ-034 SHALL cover: shift 16 bits of 16'hA5C3 then key_done -> unlocked=1 next cycle; in_data=32'h00000001 -> out_data=32'h80000001.
REQ-035 SHALL cover: 15 shifts then key_done -> key_err pulse, LOCKED, bit_cnt=0, unlocked=0.
REQ-036 SHALL cover: with LOCK_BLOCK_EN, three wrong keys -> BLOCKED; in_data=32'hFFFFFFFF -> out_data=0; further correct key ignored; rst -> LOCKED.
REQ-037 SHALL cover: key_shift and key_done asserted in the same cycle -> shift ignored and check performed; words issued one cycle before unlock emerge still masked.
REQ-038 SHALL cover: rst asserted mid-stream with 2 words in flight -> no out_valid in the following 2 cycles.

Source files
------------

// File: rtl/locked_seq_core.sv
// Key-locked combinational core behind a fixed-latency pipeline; output is masked until unlocked.
// Optional LOCK_BLOCK_EN: repeated failed key checks park the FSM in BLOCKED until reset.
module locked_seq_core #(
   parameter int                IN_W     = 32,
   parameter int                OUT_W    = 32,
   parameter int                KEY_W    = 16,
   parameter logic [KEY_W-1:0]  KEY_VAL  = 16'hA5C3,
   parameter int                STAGES   = 2,
   parameter int                MAX_FAIL = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IN_W-1:0]               in_data,
   input  logic                          in_valid,
   input  logic                          key_bit,
   input  logic                          key_shift,
   input  logic                          key_done,
   output logic [OUT_W-1:0]              out_data,
   output logic                          out_valid,
   output logic                          unlocked,
   output logic                          key_err,
   output logic [1:0]                    dbg_state,
   output logic [$clog2(KEY_W+1)-1:0]    dbg_bit_cnt
);

   localparam int CNT_W = $clog2(KEY_W + 1);
   localparam logic [CNT_W-1:0] KEY_CNT  = CNT_W'(KEY_W);
   localparam logic [2:0]       FAIL_MAX = 3'(MAX_FAIL);

   typedef enum logic [1:0] {
      ST_LOCKED   = 2'd0,
      ST_LOADING  = 2'd1,
      ST_UNLOCKED = 2'd2,
      ST_BLOCKED  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   key_reg_q, key_reg_d;
   logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [2:0]         fail_cnt_q, fail_cnt_d;
   logic               key_err_q, key_err_d;

   logic [OUT_W-1:0]   pipe_data_q [STAGES];
   logic [OUT_W-1:0]   pipe_data_d [STAGES];
   logic [STAGES-1:0]  pipe_valid_q, pipe_valid_d;

   logic [OUT_W-1:0]   core_y;
   logic [OUT_W-1:0]   mask;
   logic [OUT_W-1:0]   stage_in;
   logic [2:0]         fail_inc;

   // Key FSM: key_done wins over key_shift; UNLOCKED and BLOCKED ignore all key inputs.
   always_comb begin
      state_d    = state_q;
      key_reg_d  = key_reg_q;
      bit_cnt_d  = bit_cnt_q;
      fail_cnt_d = fail_cnt_q;
      key_err_d  = 1'b0;
      fail_inc   = (fail_cnt_q < FAIL_MAX) ? fail_cnt_q + 3'd1 : fail_cnt_q;
      case (state_q)
         ST_LOCKED, ST_LOADING: begin
            if (key_done) begin
               if ((bit_cnt_q == KEY_CNT) && (key_reg_q == KEY_VAL)) begin
                  state_d    = ST_UNLOCKED;
                  fail_cnt_d = 3'd0;
               end else begin
                  key_err_d  = 1'b1;
                  bit_cnt_d  = '0;
                  fail_cnt_d = fail_inc;
                  state_d    = ST_LOCKED;
`ifdef LOCK_BLOCK_EN
                  if (fail_inc == FAIL_MAX) begin
                     state_d = ST_BLOCKED;
                  end
`endif
               end
            end else if (key_shift) begin
               key_reg_d = {key_reg_q[KEY_W-2:0], key_bit};
               if (bit_cnt_q < KEY_CNT) begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
               state_d = ST_LOADING;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      core_y = '0;
      for (int j = 0; j < OUT_W; j++) begin
         core_y[j] = in_data[j % IN_W] ^ (in_data[(j + 1) % IN_W] & ~in_data[(j + 2) % IN_W]);
      end
   end

   // The mask is captured together with the word, so later key changes never touch words in flight.
   always_comb begin
      mask = (state_q == ST_UNLOCKED) ? '0 : {(OUT_W / KEY_W){key_reg_q ^ KEY_VAL}};
      stage_in = (state_q == ST_BLOCKED) ? '0 : (core_y ^ mask);
   end

   always_comb begin
      pipe_valid_d    = '0;
      pipe_valid_d[0] = in_valid;
      pipe_data_d[0]  = in_valid ? stage_in : pipe_data_q[0];
      for (int i = 1; i < STAGES; i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
         pipe_data_d[i]  = pipe_valid_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LOCKED;
         key_reg_q    <= '0;
         bit_cnt_q    <= '0;
         fail_cnt_q   <= 3'd0;
         key_err_q    <= 1'b0;
         pipe_valid_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            pipe_data_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         key_reg_q    <= key_reg_d;
         bit_cnt_q    <= bit_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         key_err_q    <= key_err_d;
         pipe_valid_q <= pipe_valid_d;
         for (int i = 0; i < STAGES; i++) begin
            pipe_data_q[i] <= pipe_data_d[i];
         end
      end
   end

   assign out_valid   = pipe_valid_q[STAGES-1];
   assign out_data    = (state_q == ST_BLOCKED) ? '0 : pipe_data_q[STAGES-1];
   assign unlocked    = (state_q == ST_UNLOCKED);
   assign key_err     = key_err_q;
   assign dbg_state   = state_q;
   assign dbg_bit_cnt = bit_cnt_q;

endmodule
